// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command-link initiator.
// Holds the opcode encodings, the controller state enum and the
// command-word width helper used by spi_master and spi_sclk_gen.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_CMD,
    ST_TURN,
    ST_SHIFT_RD,
    ST_GUARD
  } spi_state_e;

  // Command word = 2-bit opcode + payload.
  function automatic int CMD_BITS(input int word_size);
    return word_size + 2;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter plus the sclk register.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   en_i        run the counter (frame in progress)
//   clr_i       force counter to 0 and sclk low
//   sclk_o      registered SPI clock, idle low
//   rise_en_o   strobe: the coming edge drives sclk 0->1
//   fall_en_o   strobe: the coming edge drives sclk 1->0 (end of a bit)
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_en_o,
  output logic fall_en_o
);

  localparam int HP_W = $clog2(CLK_DIV + 1);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            wrap;

  assign wrap = en_i && !clr_i && (cnt_q == HP_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en_i) begin
      if (wrap) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign rise_en_o = wrap && !sclk_q;
  assign fall_en_o = wrap && sclk_q;

endmodule

// File: rtl/spi_master.sv
// SPI initiator for the 10-bit command link into the slave/RAM path.
// Accepts a command word over valid/ready, frames it MSB first on
// ss_n/sclk/mosi and, for read-data, clocks the response byte in on miso.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   cmd_valid    host command request
//   cmd_ready    high in IDLE while rst is low
//   cmd_din      {opcode[1:0], payload[WORD_SIZE-1:0]}
//   rd_valid     one-cycle pulse when rd_data updates
//   rd_data      byte received on miso
//   busy         high whenever not IDLE
//   sclk, ss_n, mosi, miso   SPI bus (sclk idle low, ss_n active low)
module spi_master
  import spi_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int CLK_DIV   = 2,
  parameter int TURN_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WORD_SIZE+1:0] cmd_din,
  output logic                 rd_valid,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 busy,
  output logic                 sclk,
  output logic                 ss_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int CW    = CMD_BITS(WORD_SIZE);
  localparam int BIT_W = $clog2(2*WORD_SIZE + 2 + TURN_BITS + 1);
  localparam int GW    = $clog2(2*CLK_DIV + 1);

  // Bit counter runs across the whole frame; these mark the last bit of each phase.
  localparam logic [BIT_W-1:0] LAST_CMD  = BIT_W'(CW - 1);
  localparam logic [BIT_W-1:0] LAST_TURN = BIT_W'(CW + TURN_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_RD   = BIT_W'(CW + TURN_BITS + WORD_SIZE - 1);
  localparam logic [GW-1:0]    LAST_GRD  = GW'(2*CLK_DIV - 1);

  spi_state_e           state_q, state_d;
  logic [CW-1:0]        sr_q, sr_d;
  logic [1:0]           op_q, op_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]        guard_cnt_q, guard_cnt_d;
  logic [WORD_SIZE-1:0] rx_q, rx_d, rx_shift;
  logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 ss_n_q, ss_n_d;
  logic                 mosi_q, mosi_d;

  logic sclk_en, rise_en, fall_en, accept;
  logic sclk_rise_unused;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign sclk_en   = (state_q == ST_SHIFT_CMD) || (state_q == ST_TURN) ||
                     (state_q == ST_SHIFT_RD);
  assign rx_shift  = {rx_q[WORD_SIZE-2:0], miso};

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en_i      (sclk_en),
    .clr_i     (!sclk_en),
    .sclk_o    (sclk),
    .rise_en_o (rise_en),
    .fall_en_o (fall_en)
  );

  // Every transition happens on a bit boundary, so only the falling strobe matters here.
  assign sclk_rise_unused = rise_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SHIFT_CMD;
      ST_SHIFT_CMD: begin
        if (fall_en && bit_cnt_q == LAST_CMD) begin
          case (op_q)
            CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR: state_d = ST_GUARD;
            CMD_RD_DATA: state_d = (TURN_BITS > 0) ? ST_TURN : ST_SHIFT_RD;
            default:     state_d = ST_GUARD;
          endcase
        end
      end
      ST_TURN:     if (fall_en && bit_cnt_q == LAST_TURN) state_d = ST_SHIFT_RD;
      ST_SHIFT_RD: if (fall_en && bit_cnt_q == LAST_RD)   state_d = ST_GUARD;
      ST_GUARD:    if (guard_cnt_q == LAST_GRD)           state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    sr_d        = sr_q;
    op_d        = op_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    guard_cnt_d = '0;
    mosi_d      = 1'b0;
    // ss_n follows the state being entered, so it rises on the same edge as the last sclk fall.
    ss_n_d      = !((state_d == ST_SHIFT_CMD) || (state_d == ST_TURN) ||
                    (state_d == ST_SHIFT_RD));

    if (fall_en) bit_cnt_d = bit_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sr_d      = cmd_din;
          op_d      = cmd_din[CW-1 -: 2];
          mosi_d    = cmd_din[CW-1];
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT_CMD: begin
        // mosi only moves on the sclk fall; it drops to 0 after the last command bit.
        mosi_d = mosi_q;
        if (fall_en) begin
          sr_d   = sr_q << 1;
          mosi_d = (bit_cnt_q == LAST_CMD) ? 1'b0 : sr_q[CW-2];
        end
      end
      ST_SHIFT_RD: begin
        if (fall_en) begin
          rx_d = rx_shift;
          if (bit_cnt_q == LAST_RD) begin
            rd_data_d  = rx_shift;
            rd_valid_d = 1'b1;
          end
        end
      end
      ST_GUARD: guard_cnt_d = guard_cnt_q + 1'b1;
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      bit_cnt_q   <= '0;
      guard_cnt_q <= '0;
    end else begin
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      bit_cnt_q   <= bit_cnt_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
    op_q <= op_d;
    rx_q <= rx_d;
  end

  assign ss_n     = ss_n_q;
  assign mosi     = mosi_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Initiator end of the 10-bit SPI command link into the slave/RAM path.
- Accepts a command word from the host over a valid/ready handshake, then frames it on SS_n/SCLK/MOSI.
- Commands: write-addr, write-data, read-addr, read-data.
- For read-data it also clocks the slave's response byte in on MISO and returns it to the host with a one-cycle valid pulse.

Parameters:
- WORD_SIZE, 8, data/address width; the command word is WORD_SIZE+2 bits.
- CLK_DIV, 2, SCLK half-period in clk cycles; legal range is 1 or more.
- TURN_BITS, 1, dummy SCLK periods between the read-data command and the response byte, to cover slave/RAM latency.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  high only in IDLE and while rst is low; a command is accepted on a clk edge where cmd_valid and cmd_ready are both high.
- cmd_din  in  WORD_SIZE+2  [WORD_SIZE+1:WORD_SIZE] is the opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data); low bits are the payload.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- rd_data  out  WORD_SIZE  byte received on MISO.
- busy  out  1  high whenever state is not IDLE.
- sclk  out  1  SPI clock, idle low.
- ss_n  out  1  slave select, active low.
- mosi  out  1  serial data to the slave, MSB first.
- miso  in  1  serial data from the slave, MSB first.

Behaviour:
- All outputs are registered except cmd_ready and busy, which decode the state.
- Reset values: ss_n=1, sclk=0, mosi=0, rd_valid=0, rd_data=0, state=IDLE.
- While rst is high, cmd_ready=0.
- Reset mid-frame aborts the frame immediately: ss_n rises on the next edge, and no rd_valid is produced.
- States: IDLE, SHIFT_CMD, TURN, SHIFT_RD, GUARD.
- Accept edge, in IDLE:
  - the shift register loads cmd_din;
  - the opcode is latched;
  - ss_n goes 0, mosi = cmd_din[WORD_SIZE+1], sclk = 0;
  - the state moves to SHIFT_CMD.
- Bit timing, for every SPI bit (command, turnaround and response alike):
  - CLK_DIV clk cycles with sclk=0, then CLK_DIV clk cycles with sclk=1.
  - mosi is stable for the whole bit period.
  - mosi changes only on the edge that drives sclk 1->0, never while sclk=1.
- SHIFT_CMD:
  - WORD_SIZE+2 bits, MSB first.
  - At the end of the last bit: opcode 11 goes to TURN; any other opcode goes to GUARD.
- TURN: TURN_BITS bits with mosi=0; MISO is ignored. Then go to SHIFT_RD.
- SHIFT_RD:
  - WORD_SIZE bits with mosi=0.
  - miso is captured into the receive shifter (MSB first) on the clk edge ending each high phase, i.e. the edge that drives sclk 1->0.
  - After the last bit, go to GUARD.
- GUARD:
  - ss_n=1, sclk=0, mosi=0 for 2*CLK_DIV clk cycles, then IDLE.
  - On entry from SHIFT_RD: rd_data gets the assembled byte and rd_valid=1 on that same edge, so it is high in the first GUARD cycle only.
- ss_n low duration:
  - non-read frame: (WORD_SIZE+2)*2*CLK_DIV clk cycles;
  - read-data frame: (WORD_SIZE+2+TURN_BITS+WORD_SIZE)*2*CLK_DIV clk cycles.
- Back-to-back: a cmd_valid held high is accepted on the first IDLE cycle after GUARD. The minimum gap between frames is 2*CLK_DIV+1 cycles with ss_n high.
- cmd_din is sampled only on the accept edge; later changes have no effect on the frame in flight.
- The bit counter width is clog2(2*WORD_SIZE+2+TURN_BITS+1). The half-period counter is clog2(CLK_DIV+1) bits, wraps to 0, and toggles sclk on reaching CLK_DIV-1.
- CLK_DIV=1: sclk toggles every clk cycle, and all the rules above still hold.

Decomposition:
- Package spi_pkg holds:
  - opcode constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - the state enum;
  - a CMD_BITS(WORD_SIZE) function.
- One sub-module, spi_sclk_gen:
  - half-period counter plus sclk register, with enable/clear;
  - outputs rise_en and fall_en strobes to the main FSM.

Test Plan:
- Write-address frame: CLK_DIV=2, cmd_din=10'b00_1010_0101 -> ss_n low for exactly 40 clk cycles; mosi bits across the 10 sclk periods read 0010100101; cmd_ready low for 44 cycles, then high.
- Read-data frame: cmd_din=10'b11_0000_0000; slave model drives 8'hC3 MSB first after 1 turnaround bit -> 19 sclk periods; rd_valid pulses once, in the first cycle after ss_n rises, with rd_data=8'hC3.
- Back-to-back: cmd_valid held high with wr-addr 0x10 then wr-data 0x5A -> two frames separated by exactly 5 clk cycles of ss_n=1 (CLK_DIV=2); the second frame's mosi bits read 0101011010.
- Reset mid-read: assert rst during bit 14 of a read frame -> on the next edge ss_n=1, sclk=0, and rd_valid never pulses; cmd_ready=1 on the first cycle after rst drops.
- CLK_DIV=1 with rd-addr 0xFF -> sclk toggles every cycle; ss_n low 20 cycles; mosi bits 1011111111; no rd_valid.
- cmd_din changed mid-frame (0x0AA to 0x155) -> the transmitted bits still match 0x0AA.
